// File: rtl/hilo_seq_if.sv
// Bundle of the signals between the control unit, the HI/LO sequencer and the
// div/mult units. The sequencer connects through the slave modport. The
// control unit and the units connect through the master modport.
//
// Handshake contract:
//   - StartDiv/StartMult are single-cycle requests. They are accepted only
//     while Busy is low.
//   - DivCtrl/MultCtrl are level starts. They stay high until the unit reports
//     DivDone/Div0/MultDone, or until the timeout expires.
//   - MdDone, Div0Exc and MdTimeout are one-cycle completion pulses.
//   - Stall tells the control unit to hold its request while Busy is high.
//   - Requests made while Busy is high are dropped, not queued.
interface hilo_seq_if;
    // control unit -> sequencer
    logic        StartDiv;
    logic        StartMult;
    logic        MtHi;
    logic        MtLo;
    logic        MfSel;
    logic        MfReq;
    logic [31:0] RegAOut;
    logic [31:0] RegBOut;
    // sequencer -> units
    logic        DivCtrl;
    logic        MultCtrl;
    logic [31:0] OpA;
    logic [31:0] OpB;
    // units -> sequencer
    logic        DivDone;
    logic        Div0;
    logic [31:0] DivHI;
    logic [31:0] DivLO;
    logic        MultDone;
    logic [31:0] MultHI;
    logic [31:0] MultLO;
    // sequencer -> control unit
    logic [31:0] HiLoOut;
    logic        Busy;
    logic        Stall;
    logic        MdDone;
    logic        Div0Exc;
    logic        MdTimeout;

    modport slave (
        input  StartDiv, StartMult, MtHi, MtLo, MfSel, MfReq, RegAOut, RegBOut,
        input  DivDone, Div0, DivHI, DivLO, MultDone, MultHI, MultLO,
        output DivCtrl, MultCtrl, OpA, OpB,
        output HiLoOut, Busy, Stall, MdDone, Div0Exc, MdTimeout
    );

    modport master (
        output StartDiv, StartMult, MtHi, MtLo, MfSel, MfReq, RegAOut, RegBOut,
        output DivDone, Div0, DivHI, DivLO, MultDone, MultHI, MultLO,
        input  DivCtrl, MultCtrl, OpA, OpB,
        input  HiLoOut, Busy, Stall, MdDone, Div0Exc, MdTimeout
    );
endinterface

// File: rtl/hilo_seq.sv
// HI/LO sequencer.
// - Owns the architectural HI/LO registers.
// - Launches a divide or multiply and holds the unit's level start until the
//   unit reports.
// - Captures the unit's HI/LO result.
// - Serves mfhi/mflo/mthi/mtlo.
// - Raises done, divide-by-zero and timeout pulses.
// The FSM state is exported on dbg_state_o so checkers can follow it.
module hilo_seq #(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic       clk,
    input  logic       reset,
    hilo_seq_if.slave  hl,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DIV_WAIT  = 3'd1,
        S_MULT_WAIT = 3'd2,
        S_DONE      = 3'd3,
        S_EXC       = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [CW-1:0] cnt_q;
    logic        div_ctrl_q;
    logic        mult_ctrl_q;
    logic        md_done_q;
    logic        div0_exc_q;
    logic        timeout_q;

    logic [CW-1:0] cnt_d;
    logic          timeout_hit;
    logic          busy;
    logic          any_req;

    // Wait-counter helpers: the next count, and whether this is the last
    // cycle the unit is allowed to take.
    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end

    // Busy/stall decode. Any request made while busy is stalled, including mf*.
    always_comb begin
        busy    = (state_q != S_IDLE);
        any_req = hl.StartDiv | hl.StartMult | hl.MtHi | hl.MtLo | hl.MfReq;
    end

    // Sequencer FSM. Every output it drives is registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            div_ctrl_q  <= 1'b0;
            mult_ctrl_q <= 1'b0;
            md_done_q   <= 1'b0;
            div0_exc_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // Completion outputs are one-cycle pulses unless re-armed below.
            md_done_q  <= 1'b0;
            div0_exc_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (hl.StartDiv) begin
                        // A divide wins over a simultaneous multiply.
                        opa_q      <= hl.RegAOut;
                        opb_q      <= hl.RegBOut;
                        div_ctrl_q <= 1'b1;
                        state_q    <= S_DIV_WAIT;
                    end else if (hl.StartMult) begin
                        opa_q       <= hl.RegAOut;
                        opb_q       <= hl.RegBOut;
                        mult_ctrl_q <= 1'b1;
                        state_q     <= S_MULT_WAIT;
                    end else begin
                        // mthi and mtlo may be issued together.
                        if (hl.MtHi) begin
                            hi_q <= hl.RegAOut;
                        end
                        if (hl.MtLo) begin
                            lo_q <= hl.RegAOut;
                        end
                    end
                end
                S_DIV_WAIT: begin
                    cnt_q <= cnt_d;
                    if (hl.Div0) begin
                        // Divide-by-zero leaves HI/LO untouched, even if done is also raised.
                        div_ctrl_q <= 1'b0;
                        div0_exc_q <= 1'b1;
                        state_q    <= S_EXC;
                    end else if (hl.DivDone) begin
                        hi_q       <= hl.DivHI;
                        lo_q       <= hl.DivLO;
                        div_ctrl_q <= 1'b0;
                        md_done_q  <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (timeout_hit) begin
                        div_ctrl_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= S_EXC;
                    end
                end
                S_MULT_WAIT: begin
                    cnt_q <= cnt_d;
                    if (hl.MultDone) begin
                        hi_q        <= hl.MultHI;
                        lo_q        <= hl.MultLO;
                        mult_ctrl_q <= 1'b0;
                        md_done_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (timeout_hit) begin
                        mult_ctrl_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        state_q     <= S_EXC;
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                S_EXC: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q       <= '0;
                    div_ctrl_q  <= 1'b0;
                    mult_ctrl_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive. HiLoOut is a plain mux so an mf* can complete in the same cycle.
    always_comb begin
        hl.DivCtrl   = div_ctrl_q;
        hl.MultCtrl  = mult_ctrl_q;
        hl.OpA       = opa_q;
        hl.OpB       = opb_q;
        hl.HiLoOut   = hl.MfSel ? hi_q : lo_q;
        hl.Busy      = busy;
        hl.Stall     = busy & any_req;
        hl.MdDone    = md_done_q;
        hl.Div0Exc   = div0_exc_q;
        hl.MdTimeout = timeout_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_hilo_seq.sv
// Testbench for hilo_seq.
// - Stand-in div/mult units compute results from the OpA/OpB the DUT presents.
// - The bench keeps its own reference HI/LO values.
// - Expected completions and expected read data go into queues.
// - A monitor pops those queues whenever the DUT pulses a completion or
//   serves a read.
module tb_hilo_seq;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    hilo_seq_if hl();

    hilo_seq #(.TIMEOUT(TIMEOUT), .CW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .hl         (hl),
        .dbg_state_o(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference architectural state.
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    // Completion event queue. Each entry is {kind, hi, lo}.
    // kind: 1 = done, 2 = divide by zero, 3 = timeout.
    logic [65:0] exp_evt_q[$];
    // Read queue. Each entry is {stall, data}.
    logic [32:0] exp_rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (hl.MdDone | hl.Div0Exc | hl.MdTimeout) begin
                logic [65:0] e;
                logic [1:0]  kind;
                kind = hl.MdDone ? 2'd1 : (hl.Div0Exc ? 2'd2 : 2'd3);
                check("one_pulse", 64'(hl.MdDone) + 64'(hl.Div0Exc) + 64'(hl.MdTimeout), 1);
                if (exp_evt_q.size() == 0) begin
                    check("unexpected_pulse", 64'(kind), 0);
                end else begin
                    e = exp_evt_q.pop_front();
                    check("evt_kind", 64'(kind), 64'(e[65:64]));
                    check("evt_hilo", hl.HiLoOut, hl.MfSel ? e[63:32] : e[31:0]);
                end
            end
            if (hl.MfReq) begin
                logic [32:0] r;
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    r = exp_rd_q.pop_front();
                    check("rd_data", hl.HiLoOut, r[31:0]);
                    check("rd_stall", hl.Stall, r[32]);
                end
            end
        end
    end

    task automatic clear_req();
        hl.StartDiv  = 1'b0;
        hl.StartMult = 1'b0;
        hl.MtHi      = 1'b0;
        hl.MtLo      = 1'b0;
        hl.MfReq     = 1'b0;
    endtask

    task automatic clear_unit();
        hl.DivDone  = 1'b0;
        hl.Div0     = 1'b0;
        hl.MultDone = 1'b0;
    endtask

    // One cycle while busy, with a random request that must be ignored and stalled.
    task automatic busy_cycle();
        bit any;
        int r;
        any        = 1'b1;
        r          = $urandom_range(0, 6);
        hl.MfSel   = 1'($urandom_range(0, 1));
        hl.RegAOut = $urandom;
        hl.RegBOut = $urandom;
        case (r)
            0: hl.MtHi = 1'b1;
            1: hl.MtLo = 1'b1;
            2: begin hl.MtHi = 1'b1; hl.MtLo = 1'b1; end
            3: hl.StartMult = 1'b1;
            4: hl.StartDiv = 1'b1;
            5: begin
                hl.MfReq = 1'b1;
                exp_rd_q.push_back({1'b1, hl.MfSel ? ref_hi : ref_lo});
            end
            default: any = 1'b0;
        endcase
        #1 check("stall_busy", hl.Stall, any);
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic do_read(input bit sel);
        hl.MfSel = sel;
        hl.MfReq = 1'b1;
        exp_rd_q.push_back({1'b0, sel ? ref_hi : ref_lo});
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic do_mt(input bit hi_en, input bit lo_en, input logic [31:0] a);
        hl.RegAOut = a;
        hl.MtHi    = hi_en;
        hl.MtLo    = lo_en;
        #1 check("stall_mt", hl.Stall, 0);
        @(posedge clk); #1;
        clear_req();
        if (hi_en) ref_hi = a;
        if (lo_en) ref_lo = a;
    endtask

    // mode: 0 = unit finishes after lat cycles, 1 = divide by zero, 2 = unit never answers
    task automatic do_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int mode, input bit both, input bit mt_too);
        logic [63:0] p;
        logic [31:0] nh;
        logic [31:0] nl;
        int          cnt;
        nh = ref_hi;
        nl = ref_lo;
        if (mode == 0) begin
            if (is_mult) begin
                p  = smul(a, b);
                nh = p[63:32];
                nl = p[31:0];
            end else begin
                nh = a % b;
                nl = a / b;
            end
        end
        exp_evt_q.push_back({2'(mode + 1), nh, nl});
        hl.RegAOut = a;
        hl.RegBOut = b;
        if (is_mult) hl.StartMult = 1'b1;
        else hl.StartDiv = 1'b1;
        if (both) hl.StartMult = 1'b1;
        if (mt_too) begin hl.MtHi = 1'b1; hl.MtLo = 1'b1; end
        #1 check("stall_start", hl.Stall, 0);
        @(posedge clk); #1;
        clear_req();
        check("ctrl_on", is_mult ? hl.MultCtrl : hl.DivCtrl, 1);
        check("ctrl_other", is_mult ? hl.DivCtrl : hl.MultCtrl, 0);
        check("busy_on", hl.Busy, 1);
        check("opa", hl.OpA, a);
        check("opb", hl.OpB, b);
        if (mode == 2) begin
            cnt = 0;
            while (!hl.MdTimeout && cnt < 60) begin
                busy_cycle();
                cnt++;
            end
            check("timeout_cycles", cnt, TIMEOUT);
            check("ctrl_off_exc", {hl.DivCtrl, hl.MultCtrl}, 0);
            check("busy_exc", hl.Busy, 1);
        end else begin
            repeat (lat) busy_cycle();
            hl.MfSel = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                if (is_mult) begin
                    p           = smul(hl.OpA, hl.OpB);
                    hl.MultDone = 1'b1;
                    hl.MultHI   = p[63:32];
                    hl.MultLO   = p[31:0];
                end else begin
                    hl.DivDone = 1'b1;
                    hl.DivHI   = hl.OpA % hl.OpB;
                    hl.DivLO   = hl.OpA / hl.OpB;
                end
            end else begin
                hl.Div0    = 1'b1;
                hl.DivDone = 1'($urandom_range(0, 1));
                hl.DivHI   = $urandom;
                hl.DivLO   = $urandom;
            end
            @(posedge clk); #1;
            clear_unit();
            check("ctrl_off", {hl.DivCtrl, hl.MultCtrl}, 0);
            check("busy_done", hl.Busy, 1);
            if (mode == 0) check("md_done", hl.MdDone, 1);
            else check("div0_exc", hl.Div0Exc, 1);
        end
        ref_hi = nh;
        ref_lo = nl;
        // Stray unit responses in DONE/EXC must not touch HI/LO.
        hl.DivDone  = 1'b1;
        hl.Div0     = 1'b1;
        hl.MultDone = 1'b1;
        hl.DivHI    = $urandom;
        hl.DivLO    = $urandom;
        hl.MultHI   = $urandom;
        hl.MultLO   = $urandom;
        @(posedge clk); #1;
        clear_unit();
        check("busy_idle", hl.Busy, 0);
        check("pulses_idle", {hl.MdDone, hl.Div0Exc, hl.MdTimeout}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset      = 1'b0;
        clear_req();
        clear_unit();
        hl.MfSel   = 1'b0;
        hl.RegAOut = '0;
        hl.RegBOut = '0;
        hl.DivHI   = '0;
        hl.DivLO   = '0;
        hl.MultHI  = '0;
        hl.MultLO  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, 0);
        check("rst_busy", hl.Busy, 0);
        check("rst_ctrl", {hl.DivCtrl, hl.MultCtrl}, 0);
        check("rst_pulses", {hl.MdDone, hl.Div0Exc, hl.MdTimeout}, 0);
        check("rst_ops", {hl.OpA, hl.OpB}, 0);
        check("rst_lo", hl.HiLoOut, 0);
        hl.MfSel = 1'b1;
        #1 check("rst_hi", hl.HiLoOut, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(1'b0, 32'd10, 32'd3, 33, 0, 1'b0, 1'b0);
        do_read(1'b1);
        do_read(1'b0);
        do_op(1'b0, 32'd5, 32'd0, 20, 1, 1'b0, 1'b0);
        do_read(1'b1);
        do_read(1'b0);
        do_op(1'b1, 32'hFFFF_FFFF, 32'd2, 32, 0, 1'b0, 1'b0);
        do_read(1'b1);
        do_read(1'b0);
        do_mt(1'b1, 1'b0, 32'h1234);
        do_read(1'b1);
        do_op(1'b0, 32'd100, 32'd7, TIMEOUT - 1, 0, 1'b0, 1'b0);
        do_read(1'b0);
        do_op(1'b0, 32'd9, 32'd4, 0, 2, 1'b0, 1'b0);
        do_op(1'b1, 32'd9, 32'd4, 0, 2, 1'b0, 1'b0);
        do_op(1'b0, 32'd77, 32'd5, 3, 0, 1'b1, 1'b1);
        do_read(1'b1);
        do_read(1'b0);

        // Reset in the middle of a multiply.
        do_mt(1'b1, 1'b1, 32'hABCD_0001);
        hl.RegAOut   = 32'd7;
        hl.RegBOut   = 32'd9;
        hl.StartMult = 1'b1;
        @(posedge clk); #1;
        clear_req();
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        ref_hi = '0;
        ref_lo = '0;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_mult", hl.MultCtrl, 0);
        check("mid_rst_busy", hl.Busy, 0);
        check("mid_rst_pulses", {hl.MdDone, hl.Div0Exc, hl.MdTimeout}, 0);
        do_read(1'b1);
        do_read(1'b0);

        // Random traffic.
        for (int i = 0; i < 30; i++) begin
            int op;
            op = $urandom_range(0, 7);
            case (op)
                0, 1: do_op(1'b0, $urandom, 32'($urandom_range(1, 32'hFFFF)),
                            $urandom_range(0, TIMEOUT - 1), 0, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                2: do_op(1'b0, $urandom, 32'd0, $urandom_range(0, TIMEOUT - 1), 1, 1'b0, 1'b0);
                3, 4: do_op(1'b1, $urandom, $urandom, $urandom_range(0, TIMEOUT - 1), 0, 1'b0,
                            1'($urandom_range(0, 1)));
                5: do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                6: do_op(1'($urandom_range(0, 1)), $urandom, $urandom, 0, 2, 1'b0, 1'b0);
                default: do_read(1'($urandom_range(0, 1)));
            endcase
            do_read(1'b1);
            do_read(1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("evt_queue_empty", exp_evt_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
